// File: rtl/vnlp_pkg.sv
// Shared widths and loader state encoding for the VNLP memory path.
package vnlp_pkg;

    localparam int unsigned ADDR_W         = 9;
    localparam int unsigned DATA_W         = 10;
    localparam int unsigned SUM_W          = ADDR_W + DATA_W;
    localparam int unsigned VNLP_MEM_DEPTH = 512;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFlush,
        StDone
    } loader_state_e;

endpackage

// File: rtl/vnlp_addr_counter.sv
// Loadable address counter with increment enable; wraps modulo 2^Width.
module vnlp_addr_counter #(
    parameter int unsigned Width = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             inc_i,
    output logic [Width-1:0] addr_o
);

    logic [Width-1:0] addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
        end else if (load_i) begin
            addr_q <= load_val_i;
        end else if (inc_i) begin
            addr_q <= addr_q + Width'(1);
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/vnlp_mem_loader.sv
// Streams Count words into consecutive memory addresses from BaseAdd, keeping a running
// checksum and pulsing Done once the final write has been committed.
module vnlp_mem_loader
    import vnlp_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAdd,
    input  logic [ADDR_W:0]   Count,
    input  logic [DATA_W-1:0] InData,
    input  logic              InValid,
    output logic              InReady,
    output logic [DATA_W-1:0] WriteData,
    output logic [ADDR_W-1:0] WriteAdd,
    output logic              WriteEn,
    output logic              Busy,
    output logic              Done,
    output logic [SUM_W-1:0]  Checksum
);

    loader_state_e     state_q;
    logic [ADDR_W:0]   remaining_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] wadd_q;
    logic              we_q;
    logic [SUM_W-1:0]  sum_q;
    logic [ADDR_W-1:0] addr;
    logic              start_acc;
    logic              transfer;

    assign start_acc = (state_q == StIdle) && Start;
    assign transfer  = (state_q == StLoad) && InValid;

    vnlp_addr_counter #(
        .Width (ADDR_W)
    ) u_addr_counter (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .load_i     (start_acc),
        .load_val_i (BaseAdd),
        .inc_i      (transfer),
        .addr_o     (addr)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            wdata_q     <= '0;
            wadd_q      <= '0;
            we_q        <= 1'b0;
            sum_q       <= '0;
        end else begin
            // The write port mirrors the accepted word one cycle later.
            we_q <= transfer;
            if (transfer) begin
                wdata_q     <= InData;
                wadd_q      <= addr;
                sum_q       <= sum_q + SUM_W'(InData);
                remaining_q <= remaining_q - 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        remaining_q <= Count;
                        sum_q       <= '0;
                        state_q     <= (Count == '0) ? StDone : StLoad;
                    end
                end
                StLoad: begin
                    if (transfer && (remaining_q == (ADDR_W+1)'(1))) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: state_q <= StDone;
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign InReady   = (state_q == StLoad);
    assign Busy      = (state_q != StIdle);
    assign Done      = (state_q == StDone);
    assign WriteEn   = we_q;
    assign WriteData = wdata_q;
    assign WriteAdd  = wadd_q;
    assign Checksum  = sum_q;

endmodule

// File: tb/tb_vnlp_mem_loader.sv
// Scoreboard bench for vnlp_mem_loader: a load-level model queues expected writes and Done
// cycles while a negedge monitor pops and compares whatever the loader presents.
module tb_vnlp_mem_loader;
    import vnlp_pkg::*;

    logic              Clk = 1'b0;
    logic              Reset, Start, InValid;
    logic [ADDR_W-1:0] BaseAdd;
    logic [ADDR_W:0]   Count;
    logic [DATA_W-1:0] InData;
    logic              InReady, WriteEn, Busy, Done;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] WriteAdd;
    logic [SUM_W-1:0]  Checksum;

    vnlp_mem_loader dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .BaseAdd   (BaseAdd),
        .Count     (Count),
        .InData    (InData),
        .InValid   (InValid),
        .InReady   (InReady),
        .WriteData (WriteData),
        .WriteAdd  (WriteAdd),
        .WriteEn   (WriteEn),
        .Busy      (Busy),
        .Done      (Done),
        .Checksum  (Checksum)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    wr_t exp_wr[$];
    int  exp_done[$];
    int  ref_mem[VNLP_MEM_DEPTH];
    int  dut_mem[VNLP_MEM_DEPTH];
    int  fixed_data[4] = '{'h001, 'h002, 'h3FF, 'h200};
    wr_t mon_w;
    int  mon_t;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every write and every Done pulse must match the head of its queue.
    always @(negedge Clk) begin
        if (WriteEn === 1'b1) begin
            dut_mem[int'(WriteAdd)] = int'(WriteData);
            if (exp_wr.size() == 0) begin
                check("unexpected write", 1, 0);
            end else begin
                mon_w = exp_wr.pop_front();
                check("write addr", 32'(WriteAdd), mon_w.addr);
                check("write data", 32'(WriteData), mon_w.data);
            end
        end
        if (Done === 1'b1) begin
            if (exp_done.size() == 0) begin
                check("unexpected done", 1, 0);
            end else begin
                mon_t = exp_done.pop_front();
                check("done cycle", cyc, mon_t);
            end
        end else if (exp_done.size() > 0 && cyc > exp_done[0]) begin
            mon_t = exp_done.pop_front();
            check("missed done", cyc, mon_t);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_done_and_verify(input int sum);
        int bad;
        for (int i = 0; i < 12 && exp_done.size() > 0; i++) tick();
        if (exp_done.size() > 0) begin
            check("done timeout", exp_done.size(), 0);
            exp_done.delete();
        end
        InValid = 1'b0;
        check("busy after done", Busy, 0);
        check("checksum", Checksum, sum);
        check("pending writes", exp_wr.size(), 0);
        bad = 0;
        for (int i = 0; i < VNLP_MEM_DEPTH; i++) if (dut_mem[i] != ref_mem[i]) bad++;
        check("readback mismatches", bad, 0);
    endtask

    // mode 0: always valid, 1: valid pattern 1,0,0,1,0,1, 2: random valid, 3: fixed data table
    task automatic do_load(input int base, input int count, input int mode, input bit poke);
        int          sent = 0;
        int          sum = 0;
        int          step = 0;
        int          a;
        bit          v;
        logic [5:0]  pat = 6'b101001;
        logic [DATA_W-1:0] d;
        Start   = 1'b1;
        BaseAdd = ADDR_W'(base);
        Count   = (ADDR_W+1)'(count);
        InValid = 1'($urandom);
        tick();
        Start   = 1'b0;
        BaseAdd = ADDR_W'($urandom);
        Count   = (ADDR_W+1)'($urandom);
        if (count == 0) begin
            exp_done.push_back(cyc);
            InValid = 1'b0;
            check("zero-count checksum cleared", Checksum, 0);
        end else begin
            while (sent < count) begin
                case (mode)
                    0, 3:    v = 1'b1;
                    1:       v = pat[step % 6];
                    default: v = 1'($urandom);
                endcase
                d = (mode == 3) ? DATA_W'(fixed_data[sent % 4]) : DATA_W'($urandom);
                InValid = v;
                InData  = d;
                if (poke) begin
                    Start   = (step == 2 || step == 3);
                    BaseAdd = ADDR_W'('h100);
                    Count   = (ADDR_W+1)'(3);
                end
                check("inready in load", InReady, 1);
                check("busy in load", Busy, 1);
                if (v) begin
                    a = (base + sent) % VNLP_MEM_DEPTH;
                    exp_wr.push_back('{a, int'(d)});
                    ref_mem[a] = int'(d);
                    sum += int'(d);
                    sent++;
                    if (sent == count) exp_done.push_back(cyc + 2);
                end
                step++;
                tick();
            end
            Start   = 1'b0;
            InValid = 1'($urandom);
            InData  = DATA_W'($urandom);
            check("inready in flush", InReady, 0);
        end
        wait_done_and_verify(sum);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < VNLP_MEM_DEPTH; i++) begin
            ref_mem[i] = 0;
            dut_mem[i] = 0;
        end
        Reset = 1'b1; Start = 1'b0; InValid = 1'b0;
        BaseAdd = '0; Count = '0; InData = '0;
        repeat (3) tick();
        check("reset writeen", WriteEn, 0);
        check("reset busy", Busy, 0);
        check("reset done", Done, 0);
        check("reset inready", InReady, 0);
        check("reset checksum", Checksum, 0);
        check("reset writeadd", WriteAdd, 0);
        check("reset writedata", WriteData, 0);
        Reset = 1'b0;
        // InValid while idle must not cause writes.
        for (int i = 0; i < 4; i++) begin
            InValid = 1'b1;
            InData  = DATA_W'($urandom);
            tick();
        end
        InValid = 1'b0;

        do_load('h010, 4, 3, 1'b0);
        check("basic checksum", Checksum, 'h602);
        do_load(int'($urandom_range(0, 511)), 3, 1, 1'b0);
        do_load('h1FE, 4, 0, 1'b0);
        do_load(int'($urandom_range(0, 511)), 0, 0, 1'b0);
        do_load('h020, 8, 0, 1'b1);

        // Reset after the second of five transfers.
        base = int'($urandom_range(0, 511));
        Start = 1'b1; BaseAdd = ADDR_W'(base); Count = (ADDR_W+1)'(5);
        tick();
        Start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d = DATA_W'($urandom);
            InValid = 1'b1;
            InData  = d;
            exp_wr.push_back('{(base + i) % VNLP_MEM_DEPTH, int'(d)});
            ref_mem[(base + i) % VNLP_MEM_DEPTH] = int'(d);
            tick();
        end
        InValid = 1'b0;
        Reset   = 1'b1;
        tick();
        Reset = 1'b0;
        check("post-reset writeen", WriteEn, 0);
        check("post-reset busy", Busy, 0);
        check("post-reset checksum", Checksum, 0);
        repeat (6) tick();
        check("post-reset pending writes", exp_wr.size(), 0);

        do_load(int'($urandom_range(0, 511)), 6, 0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            do_load(int'($urandom_range(0, 511)), int'($urandom_range(1, 40)), 2, 1'b0);
            repeat (int'($urandom_range(0, 3))) tick();
        end
        do_load(int'($urandom_range(0, 511)), 512, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vnlp_mem_loader.md
Name: vnlp_mem_loader

Overview:
- Write-side counterpart to the VNLP two-port read path; fills the Memory block through its WriteData/WriteAdd/WriteEn port, which the VNLP top currently ties off.
- Accepts a valid/ready word stream and writes Count words to consecutive addresses from BaseAdd. Pulses Done after the final write has committed.
- Keeps a running checksum of the loaded words so the bench or host can confirm the contents before asserting VNLP Start.

Parameters:
- ADDR_W, 9: memory address width; matches MemAdd1/MemAdd2.
- DATA_W, 10: memory word width; matches MemData1/MemData2.
- SUM_W, 19: checksum width, ADDR_W+DATA_W, so a full-memory sum cannot overflow.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin a load; sampled only in IDLE.
- BaseAdd  in  ADDR_W  first write address; latched on an accepted Start.
- Count  in  ADDR_W+1  number of words, 0..512; latched on an accepted Start.
- InData  in  DATA_W  stream word.
- InValid  in  1  InData is valid.
- InReady  out  1  loader accepts a word this cycle.
- WriteData  out  DATA_W  to Memory WriteData.
- WriteAdd  out  ADDR_W  to Memory WriteAdd.
- WriteEn  out  1  to Memory WriteEn.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- Checksum  out  SUM_W  sum of the words accepted in the current or most recent load.

Behaviour:
- Reset values: every output is 0 and the state is IDLE. Reset has priority over all other inputs in every state; a load interrupted by Reset is abandoned. WriteEn is 0 in the cycle after Reset is sampled.
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE
  - On Start: latch BaseAdd into the address counter and Count into the remaining counter, and clear Checksum.
  - If Count != 0, go to LOAD. If Count == 0, go to DONE; no write is issued.
  - InReady = 0.
- LOAD
  - InReady = 1.
  - A transfer occurs when InValid && InReady.
  - On a transfer in cycle t, the outputs are registered for cycle t+1:
    - WriteEn = 1
    - WriteData = InData
    - WriteAdd = address counter
  - Also on a transfer: the address counter increments modulo 2^ADDR_W (511 wraps to 0), the remaining counter decrements, and Checksum += InData with zero-extension.
  - In any cycle without a transfer, WriteEn = 0 in the next cycle.
  - When the remaining counter is 1 and a transfer occurs, go to FLUSH.
  - Throughput is one word per clock.
- FLUSH
  - InReady = 0. The final write is on the port this cycle and the memory commits it at the closing edge.
  - Go to DONE.
- DONE
  - Done = 1 for exactly one cycle, then go to IDLE.
  - Latency: last transfer at cycle t → final WriteEn in t+1 → Done in t+2. For Count == 0, Done is in the cycle after Start.
- Start is ignored while Busy = 1; it does not retrigger a load or alter BaseAdd/Count.
- InValid outside LOAD: no effect, no transfer.
- Checksum holds its value after Done until the next accepted Start.
- Count = 512 with any BaseAdd writes every location once, wrapping through 0.
- The loader never reads memory and never drives the read ports.

Decomposition:
- Shared package vnlp_pkg:
  - ADDR_W, DATA_W, SUM_W
  - loader state enum: IDLE, LOAD, FLUSH, DONE
  - VNLP_MEM_DEPTH = 512
- One natural sub-module, vnlp_addr_counter: loadable wrapping address counter with increment enable. Reused later for read-address generation.
- The FSM and the remaining counter stay in vnlp_mem_loader.

Test Plan:
- Basic load:
  - Stimulus: Start with BaseAdd=0x010, Count=4; stream 0x001, 0x002, 0x3FF, 0x200 with InValid held high.
  - Required: WriteEn high for 4 consecutive cycles at WriteAdd 0x010..0x013 with that data. Done pulses 2 cycles after the last transfer. Checksum = 0x602. Memory read-back matches.
- Backpressure gaps:
  - Stimulus: Count=3, InValid toggling 1,0,0,1,0,1.
  - Required: exactly 3 writes, at consecutive addresses, with no WriteEn in gap cycles.
- Wrap-around:
  - Stimulus: BaseAdd=0x1FE, Count=4.
  - Required: writes to 0x1FE, 0x1FF, 0x000, 0x001.
- Zero count:
  - Stimulus: Start with Count=0.
  - Required: no WriteEn. Done pulses in the next cycle. Checksum = 0.
- Start while busy:
  - Stimulus: assert Start with BaseAdd=0x100 mid-load, during a load from BaseAdd=0x020, Count=8.
  - Required: all 8 writes land at 0x020..0x027. No second load starts.
- Reset mid-load:
  - Stimulus: Reset after the 2nd of 5 transfers.
  - Required: the next cycle has WriteEn=0, Busy=0 and Checksum=0, and Done is never asserted. A new Start then loads normally.
